register_file_scoreboard: RTL and testbench

Parametrised successor to the 32-entry register file. It provides a configurable-depth, configurable-width register array with synchronous reset-to-zero and byte-lane write enables. Optional write-to-read bypass and a per-register busy scoreboard produce hazard flags for the issue stage. It sits between decode/issue and writeback in the single-cycle and upcoming multi-cycle cores, and keeps the debug read port used by the board-level display logic.

---
 rtl/register_file_scoreboard.sv | 106 ++++++++++
 tb/tb_register_file_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// Register file with byte-lane writes, optional write-to-read bypass and per-register busy scoreboard.
// Latency: reads combinational; data/busy/count update at the edge (bypass makes writes visible same cycle).
// Backpressure: none; every issue and writeback is accepted in the cycle it is presented.
module register_file_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WE,
    input  logic [WIDTH/8-1:0]    BE,
    input  logic [ADDR_W-1:0]     Rd,
    input  logic [WIDTH-1:0]      WD,
    input  logic [ADDR_W-1:0]     Rs1,
    input  logic [ADDR_W-1:0]     Rs2,
    input  logic [ADDR_W-1:0]     Debug_Source,
    output logic [WIDTH-1:0]      RD1,
    output logic [WIDTH-1:0]      RD2,
    output logic [WIDTH-1:0]      Debug_Out,
    input  logic                  Issue_Valid,
    input  logic [ADDR_W-1:0]     Issue_Rd,
    output logic                  Hazard1,
    output logic                  Hazard2,
    output logic [ADDR_W:0]       Busy_Count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / 8;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busy_nxt;
    logic [ADDR_W:0]             count_nxt;
    logic [WIDTH-1:0]            lane_mask;
    logic                        wr_act;
    logic                        iss_act;
    logic                        byp1;
    logic                        byp2;

    assign wr_act  = WE && (Rd != '0);
    assign iss_act = Issue_Valid && (Issue_Rd != '0);

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < NB; k++) begin
            lane_mask[8*k +: 8] = {8{BE[k]}};
        end
    end

    // Set is applied after clear so a same-cycle issue to the written register stays outstanding.
    always_comb begin
        busy_nxt = busy;
        if (wr_act) begin
            busy_nxt[Rd] = 1'b0;
        end
        if (iss_act) begin
            busy_nxt[Issue_Rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_nxt = count_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs       <= '0;
            busy       <= '0;
            Busy_Count <= '0;
        end else begin
            if (wr_act) begin
                for (int k = 0; k < NB; k++) begin
                    if (BE[k]) begin
                        regs[Rd][8*k +: 8] <= WD[8*k +: 8];
                    end
                end
            end
            busy       <= busy_nxt;
            Busy_Count <= count_nxt;
        end
    end

    assign byp1 = (BYPASS != 0) && wr_act && (Rs1 == Rd);
    assign byp2 = (BYPASS != 0) && wr_act && (Rs2 == Rd);

    always_comb begin
        RD1       = '0;
        RD2       = '0;
        Debug_Out = '0;
        if (Rs1 != '0) begin
            RD1 = byp1 ? ((regs[Rs1] & ~lane_mask) | (WD & lane_mask)) : regs[Rs1];
        end
        if (Rs2 != '0) begin
            RD2 = byp2 ? ((regs[Rs2] & ~lane_mask) | (WD & lane_mask)) : regs[Rs2];
        end
        if (Debug_Source != '0) begin
            Debug_Out = regs[Debug_Source];
        end
    end

    // A bypassed writeback resolves the hazard in the same cycle it retires.
    assign Hazard1 = (Rs1 != '0) && busy[Rs1] && !byp1;
    assign Hazard2 = (Rs2 != '0) && busy[Rs2] && !byp2;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: runs BYPASS=1 and BYPASS=0 instances on shared stimulus and checks queued expectations.
module tb_register_file_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [3:0]  BE;
    logic [4:0]  Rd, Rs1, Rs2, Debug_Source, Issue_Rd;
    logic [31:0] WD;
    logic        Issue_Valid;

    logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
    logic        hz1_b, hz2_b, hz1_n, hz2_n;
    logic [5:0]  cnt_b, cnt_n;

    always #5 clk = ~clk;

    register_file_scoreboard #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .WE(WE), .BE(BE), .Rd(Rd), .WD(WD),
        .Rs1(Rs1), .Rs2(Rs2), .Debug_Source(Debug_Source),
        .RD1(rd1_b), .RD2(rd2_b), .Debug_Out(dbg_b),
        .Issue_Valid(Issue_Valid), .Issue_Rd(Issue_Rd),
        .Hazard1(hz1_b), .Hazard2(hz2_b), .Busy_Count(cnt_b)
    );

    register_file_scoreboard #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .WE(WE), .BE(BE), .Rd(Rd), .WD(WD),
        .Rs1(Rs1), .Rs2(Rs2), .Debug_Source(Debug_Source),
        .RD1(rd1_n), .RD2(rd2_n), .Debug_Out(dbg_n),
        .Issue_Valid(Issue_Valid), .Issue_Rd(Issue_Rd),
        .Hazard1(hz1_n), .Hazard2(hz2_n), .Busy_Count(cnt_n)
    );

    localparam int S_RD1 = 0, S_RD2 = 1, S_DBG = 2, S_HZ1 = 3, S_HZ2 = 4, S_CNT = 5;
    localparam int N_RD1 = 6, N_RD2 = 7, N_DBG = 8, N_HZ1 = 9, N_HZ2 = 10, N_CNT = 11;

    int n_checks = 0;
    int n_err    = 0;

    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];

    logic [31:0] mem [32];
    logic [31:0] busy_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD1:   return rd1_b;
            S_RD2:   return rd2_b;
            S_DBG:   return dbg_b;
            S_HZ1:   return {31'b0, hz1_b};
            S_HZ2:   return {31'b0, hz2_b};
            S_CNT:   return {26'b0, cnt_b};
            N_RD1:   return rd1_n;
            N_RD2:   return rd2_n;
            N_DBG:   return dbg_n;
            N_HZ1:   return {31'b0, hz1_n};
            N_HZ2:   return {31'b0, hz2_n};
            default: return {26'b0, cnt_n};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    // Compare queued expectations mid-cycle, then advance past the next rising edge.
    task automatic cycle();
        string       t;
        int          s;
        logic [31:0] e;
        @(negedge clk);
        while (sel_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            chk(t, observe(s), e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic we, input logic [3:0] be, input logic [4:0] rd,
                          input logic [31:0] wd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] dbg, input logic iv, input logic [4:0] ird);
        WE = we; BE = be; Rd = rd; WD = wd; Rs1 = rs1; Rs2 = rs2;
        Debug_Source = dbg; Issue_Valid = iv; Issue_Rd = ird;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        logic [31:0] msk;
        if (a == 5'd0) return 32'h0;
        msk = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
        v = mem[a];
        if (byp && WE && Rd != 5'd0 && a == Rd) v = (v & ~msk) | (WD & msk);
        return v;
    endfunction

    function automatic logic [31:0] m_hz(input logic [4:0] a, input bit byp);
        return {31'b0, (a != 5'd0) && busy_m[a] && !(byp && WE && Rd == a)};
    endfunction

    task automatic m_update();
        logic [31:0] msk;
        msk = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            busy_m = 32'h0;
        end else begin
            if (WE && Rd != 5'd0) begin
                mem[Rd] = (mem[Rd] & ~msk) | (WD & msk);
                busy_m[Rd] = 1'b0;
            end
            if (Issue_Valid && Issue_Rd != 5'd0) busy_m[Issue_Rd] = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Power-up reset state
        set_in(0, 4'h0, 0, 0, 1, 2, 31, 0, 0);
        expect_out("init_rd1", S_RD1, 0);
        expect_out("init_dbg", S_DBG, 0);
        expect_out("init_hz1", S_HZ1, 0);
        expect_out("init_cnt", S_CNT, 0);
        cycle();

        // Mid-operation reset
        set_in(1, 4'hF, 5, 32'hDEADBEEF, 0, 0, 0, 1, 6);
        cycle();
        set_in(0, 4'h0, 0, 0, 5, 6, 5, 0, 0);
        expect_out("pre_rst_rd1", S_RD1, 32'hDEADBEEF);
        expect_out("pre_rst_dbg", S_DBG, 32'hDEADBEEF);
        expect_out("pre_rst_hz2", S_HZ2, 1);
        expect_out("pre_rst_cnt", S_CNT, 1);
        cycle();
        reset = 1'b1;
        set_in(1, 4'hF, 7, 32'h77, 0, 0, 0, 1, 8);
        cycle();
        reset = 1'b0;
        set_in(0, 4'h0, 0, 0, 5, 6, 7, 0, 0);
        expect_out("rst_rd1", S_RD1, 0);
        expect_out("rst_hz1", S_HZ1, 0);
        expect_out("rst_hz2", S_HZ2, 0);
        expect_out("rst_dbg_override", S_DBG, 0);
        expect_out("rst_cnt", S_CNT, 0);
        cycle();
        set_in(1, 4'hF, 6, 32'h55, 0, 6, 0, 0, 0);
        expect_out("wb_after_rst_hz2_nb", N_HZ2, 0);
        cycle();
        set_in(0, 4'h0, 0, 0, 0, 6, 8, 0, 0);
        expect_out("wb_after_rst_rd2", S_RD2, 32'h55);
        expect_out("wb_after_rst_cnt", S_CNT, 0);
        cycle();

        // Byte lanes
        set_in(1, 4'hF, 7, 32'h11223344, 0, 0, 0, 0, 0);
        cycle();
        set_in(1, 4'h5, 7, 32'hAABBCCDD, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 4'h0, 0, 0, 7, 0, 7, 0, 0);
        expect_out("lanes_rd1", S_RD1, 32'h11BB33DD);
        expect_out("lanes_rd1_nb", N_RD1, 32'h11BB33DD);
        cycle();

        // Bypass versus no bypass; debug port never bypassed
        set_in(1, 4'hF, 3, 32'h0000FFFF, 0, 0, 0, 0, 0);
        cycle();
        set_in(1, 4'h3, 3, 32'h12345678, 3, 3, 3, 0, 0);
        expect_out("byp_rd1", S_RD1, 32'h00005678);
        expect_out("byp_rd2", S_RD2, 32'h00005678);
        expect_out("nobyp_rd1", N_RD1, 32'h0000FFFF);
        expect_out("byp_dbg", S_DBG, 32'h0000FFFF);
        cycle();
        set_in(0, 4'h0, 0, 0, 3, 0, 0, 0, 0);
        expect_out("after_byp_rd1_nb", N_RD1, 32'h00005678);
        cycle();

        // Register 0
        set_in(1, 4'hF, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
        expect_out("x0_rd1", S_RD1, 0);
        expect_out("x0_hz1", S_HZ1, 0);
        cycle();
        set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("x0_rd1_next", S_RD1, 0);
        expect_out("x0_dbg_next", S_DBG, 0);
        expect_out("x0_cnt", S_CNT, 0);
        cycle();

        // Scoreboard: issue r4, hold, writeback
        set_in(0, 4'h0, 0, 0, 4, 0, 0, 1, 4);
        expect_out("sb_c1_hz1", S_HZ1, 0);
        cycle();
        for (int c = 2; c <= 4; c++) begin
            set_in(0, 4'h0, 0, 0, 4, 0, 0, 0, 0);
            expect_out($sformatf("sb_c%0d_hz1", c), S_HZ1, 1);
            expect_out($sformatf("sb_c%0d_hz1_nb", c), N_HZ1, 1);
            expect_out($sformatf("sb_c%0d_cnt", c), S_CNT, 1);
            cycle();
        end
        set_in(1, 4'hF, 4, 32'h44, 4, 0, 0, 0, 0);
        expect_out("sb_c5_hz1", S_HZ1, 0);
        expect_out("sb_c5_hz1_nb", N_HZ1, 1);
        expect_out("sb_c5_cnt", S_CNT, 1);
        cycle();
        set_in(0, 4'h0, 0, 0, 4, 0, 0, 0, 0);
        expect_out("sb_c6_cnt", S_CNT, 0);
        expect_out("sb_c6_hz1_nb", N_HZ1, 0);
        cycle();

        // Simultaneous issue and writeback on a busy register
        set_in(0, 4'h0, 0, 0, 0, 0, 0, 1, 9);
        cycle();
        set_in(1, 4'hF, 9, 32'hCAFEF00D, 0, 9, 0, 1, 9);
        expect_out("sim_cnt_before", S_CNT, 1);
        expect_out("sim_hz2_byp", S_HZ2, 0);
        expect_out("sim_hz2_nb", N_HZ2, 1);
        cycle();
        set_in(0, 4'h0, 0, 0, 0, 9, 0, 0, 0);
        expect_out("sim_cnt_after", S_CNT, 1);
        expect_out("sim_hz2_after", S_HZ2, 1);
        expect_out("sim_rd2", S_RD2, 32'hCAFEF00D);
        cycle();
        set_in(1, 4'h0, 9, 0, 0, 9, 0, 0, 0);
        cycle();
        set_in(0, 4'h0, 0, 0, 0, 9, 9, 0, 0);
        expect_out("be0_wb_cnt", S_CNT, 0);
        expect_out("be0_wb_rd2", S_RD2, 32'hCAFEF00D);
        expect_out("be0_wb_dbg", S_DBG, 32'hCAFEF00D);
        cycle();

        // Highest register
        set_in(1, 4'hF, 31, 32'hA5A5A5A5, 0, 31, 31, 0, 0);
        expect_out("r31_rd2_byp", S_RD2, 32'hA5A5A5A5);
        expect_out("r31_rd2_nb", N_RD2, 0);
        expect_out("r31_dbg", S_DBG, 0);
        cycle();
        set_in(0, 4'h0, 0, 0, 0, 0, 31, 0, 0);
        expect_out("r31_dbg_next", S_DBG, 32'hA5A5A5A5);
        cycle();

        // Randomised traffic against a reference model
        reset = 1'b1;
        set_in(0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        m_update();
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) < 2);
            set_in(($urandom_range(0, 99) < 35), 4'($urandom_range(0, 15)),
                   5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)),
                   ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)));
            if (n % 53 == 0) Rd = 5'd31;
            expect_out("rnd_rd1", S_RD1, m_rd(Rs1, 1));
            expect_out("rnd_rd2", S_RD2, m_rd(Rs2, 1));
            expect_out("rnd_dbg", S_DBG, m_rd(Debug_Source, 0));
            expect_out("rnd_hz1", S_HZ1, m_hz(Rs1, 1));
            expect_out("rnd_hz2", S_HZ2, m_hz(Rs2, 1));
            expect_out("rnd_cnt", S_CNT, $countones(busy_m));
            expect_out("rnd_rd1_nb", N_RD1, m_rd(Rs1, 0));
            expect_out("rnd_hz2_nb", N_HZ2, m_hz(Rs2, 0));
            expect_out("rnd_cnt_nb", N_CNT, $countones(busy_m));
            cycle();
            m_update();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
